// File: rtl/reg_sw_access_ctrl_if.sv
// rtl/reg_sw_access_ctrl_if.sv - request/ack channel bundle between bus bridge and register access controller
interface reg_sw_access_ctrl_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  ack_vld;
    logic                  ack_rdy;
    logic [DATA_WIDTH-1:0] ack_rdata;
    logic                  ack_err;

    modport master (
        output req_vld,
        output req_wr,
        output req_addr,
        output req_wdata,
        output ack_rdy,
        input  req_rdy,
        input  ack_vld,
        input  ack_rdata,
        input  ack_err
    );

    modport slave (
        input  req_vld,
        input  req_wr,
        input  req_addr,
        input  req_wdata,
        input  ack_rdy,
        output req_rdy,
        output ack_vld,
        output ack_rdata,
        output ack_err
    );
endinterface

// File: rtl/reg_sw_access_ctrl.sv
// rtl/reg_sw_access_ctrl.sv - single-outstanding register responder driving one-hot sw_wr/sw_rd strobes
module reg_sw_access_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int REG_NUM    = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    reg_sw_access_ctrl_if.slave             bus,
    output logic [REG_NUM-1:0]              sw_wr,
    output logic [REG_NUM-1:0]              sw_rd,
    output logic [DATA_WIDTH-1:0]           sw_wr_data,
    input  logic [REG_NUM*DATA_WIDTH-1:0]   reg_rd_data
);

    localparam int BYTES      = DATA_WIDTH / 8;
    localparam int BYTE_SHIFT = $clog2(BYTES);
    localparam int IDX_W      = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

    localparam logic [ADDR_WIDTH-1:0] BASE       = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] REG_LIMIT  = ADDR_WIDTH'(REG_NUM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                  accept;
    logic                  ack_done;

    logic                  dec_borrow;
    logic [ADDR_WIDTH-1:0] dec_off;
    logic [ADDR_WIDTH-1:0] dec_slot;
    logic                  dec_hit;
    logic [IDX_W-1:0]      dec_idx;
    logic [REG_NUM-1:0]    dec_onehot;

    logic                  acc_wr;
    logic                  acc_hit;
    logic [IDX_W-1:0]      acc_idx;
    logic [DATA_WIDTH-1:0] acc_rd_sel;

    logic [DATA_WIDTH-1:0] ack_rdata_q;
    logic                  ack_err_q;

    // Address decode; the extra borrow bit flags addresses below BASE_ADDR.
    always_comb begin
        {dec_borrow, dec_off} = {1'b0, bus.req_addr} - {1'b0, BASE};
        dec_slot   = dec_off >> BYTE_SHIFT;
        dec_hit    = !dec_borrow
                     && ((dec_off & ALIGN_MASK) == '0)
                     && (dec_slot < REG_LIMIT);
        dec_idx    = dec_slot[IDX_W-1:0];
        dec_onehot = dec_hit ? (REG_NUM'(1) << dec_idx) : '0;
    end

    always_comb begin
        state_d      = state_q;
        bus.req_rdy  = 1'b0;
        bus.ack_vld  = 1'b0;
        accept       = 1'b0;
        ack_done     = 1'b0;
        case (state_q)
            IDLE: begin
                bus.req_rdy = 1'b1;
                if (bus.req_vld) begin
                    accept  = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                state_d = RESP;
            end
            RESP: begin
                bus.ack_vld = 1'b1;
                if (bus.ack_rdy) begin
                    ack_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign acc_rd_sel = reg_rd_data[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH];

    // Strobes are registered at acceptance so they are high exactly during ACCESS.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_wr      <= 1'b0;
            acc_hit     <= 1'b0;
            acc_idx     <= '0;
            sw_wr       <= '0;
            sw_rd       <= '0;
            sw_wr_data  <= '0;
            ack_rdata_q <= '0;
            ack_err_q   <= 1'b0;
        end else begin
            sw_wr <= '0;
            sw_rd <= '0;
            if (accept) begin
                acc_wr     <= bus.req_wr;
                acc_hit    <= dec_hit;
                acc_idx    <= dec_idx;
                sw_wr_data <= bus.req_wdata;
                sw_wr      <= bus.req_wr ? dec_onehot : '0;
                sw_rd      <= bus.req_wr ? '0 : dec_onehot;
            end
            // Sampled alongside the read strobe, so read-side-effect fields return the old value.
            if (state_q == ACCESS) begin
                ack_err_q   <= ~acc_hit;
                ack_rdata_q <= (acc_hit && !acc_wr) ? acc_rd_sel : '0;
            end
            if (ack_done) begin
                ack_rdata_q <= '0;
                ack_err_q   <= 1'b0;
            end
        end
    end

    assign bus.ack_rdata = ack_rdata_q;
    assign bus.ack_err   = ack_err_q;

endmodule

// File: tb/tb_reg_sw_access_ctrl.sv
// tb/tb_reg_sw_access_ctrl.sv - directed self-checking bench for reg_sw_access_ctrl
module tb_reg_sw_access_ctrl;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int RN = 4;

    logic          clk;
    logic          rst;
    logic [RN-1:0] sw_wr;
    logic [RN-1:0] sw_rd;
    logic [DW-1:0] sw_wr_data;
    logic [RN*DW-1:0] reg_rd_data;

    logic [DW-1:0] reg0;
    logic [DW-1:0] reg1;
    logic [DW-1:0] rc_field;
    logic [DW-1:0] reg3;

    int n_chk;
    int n_fail;
    logic [DW-1:0] held;

    reg_sw_access_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    reg_sw_access_ctrl #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .REG_NUM(RN),
        .BASE_ADDR(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .sw_wr(sw_wr),
        .sw_rd(sw_rd),
        .sw_wr_data(sw_wr_data),
        .reg_rd_data(reg_rd_data)
    );

    assign reg_rd_data = {reg3, rc_field, reg1, reg0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-clear field at register 2: cleared by its own read strobe.
    always @(posedge clk) begin
        if (!rst && sw_rd[2]) rc_field <= '0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        bus.req_vld   = 1'b1;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        tick();
        bus.req_vld   = 1'b0;
    endtask

    task automatic complete(input string tag);
        bus.ack_rdy = 1'b1;
        tick();
        bus.ack_rdy = 1'b0;
        check({tag, "_ackvld_low"}, 64'(bus.ack_vld), 64'h0);
        check({tag, "_rdy_back"}, 64'(bus.req_rdy), 64'h1);
        check({tag, "_rdata_clr"}, 64'(bus.ack_rdata), 64'h0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.req_vld = 1'b0;
        bus.req_wr = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        bus.ack_rdy = 1'b0;
        reg0 = 32'h1111_0000;
        reg1 = 32'h2222_1111;
        rc_field = 32'h0000_0003;
        reg3 = 32'hDEAD_BEEF;
        tick();
        tick();
        check("rst_req_rdy", 64'(bus.req_rdy), 64'h1);
        check("rst_ack_vld", 64'(bus.ack_vld), 64'h0);
        check("rst_ack_rdata", 64'(bus.ack_rdata), 64'h0);
        check("rst_ack_err", 64'(bus.ack_err), 64'h0);
        check("rst_strobes", 64'({sw_wr, sw_rd}), 64'h0);
        check("rst_wr_data", 64'(sw_wr_data), 64'h0);
        rst = 1'b0;
        tick();

        // write to register 1
        send(1'b1, 8'h04, 32'hA5A5_0001);
        check("wr1_sw_wr", 64'(sw_wr), 64'h2);
        check("wr1_sw_rd", 64'(sw_rd), 64'h0);
        check("wr1_wdata", 64'(sw_wr_data), 64'hA5A5_0001);
        check("wr1_req_rdy", 64'(bus.req_rdy), 64'h0);
        tick();
        check("wr1_sw_wr_off", 64'(sw_wr), 64'h0);
        check("wr1_ack_vld", 64'(bus.ack_vld), 64'h1);
        check("wr1_ack_err", 64'(bus.ack_err), 64'h0);
        check("wr1_ack_rdata", 64'(bus.ack_rdata), 64'h0);
        complete("wr1");

        // read register 3
        send(1'b0, 8'h0C, '0);
        check("rd3_sw_rd", 64'(sw_rd), 64'h8);
        check("rd3_sw_wr", 64'(sw_wr), 64'h0);
        tick();
        check("rd3_ack_vld", 64'(bus.ack_vld), 64'h1);
        check("rd3_rdata", 64'(bus.ack_rdata), 64'hDEAD_BEEF);
        check("rd3_err", 64'(bus.ack_err), 64'h0);
        complete("rd3");

        // unmapped address
        send(1'b0, 8'h10, '0);
        check("unmap_strobes", 64'({sw_wr, sw_rd}), 64'h0);
        tick();
        check("unmap_err", 64'(bus.ack_err), 64'h1);
        check("unmap_rdata", 64'(bus.ack_rdata), 64'h0);
        complete("unmap");

        // misaligned address, as a write
        send(1'b1, 8'h06, 32'h1234_5678);
        check("misal_strobes", 64'({sw_wr, sw_rd}), 64'h0);
        tick();
        check("misal_err", 64'(bus.ack_err), 64'h1);
        check("misal_rdata", 64'(bus.ack_rdata), 64'h0);
        complete("misal");

        // ack back-pressure with a pending request held on the channel
        send(1'b0, 8'h04, '0);
        tick();
        bus.req_vld  = 1'b1;
        bus.req_wr   = 1'b0;
        bus.req_addr = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("bp_ack_vld", 64'(bus.ack_vld), 64'h1);
            check("bp_rdata", 64'(bus.ack_rdata), 64'h2222_1111);
            check("bp_req_rdy", 64'(bus.req_rdy), 64'h0);
            check("bp_strobes", 64'({sw_wr, sw_rd}), 64'h0);
            tick();
        end
        bus.ack_rdy = 1'b1;
        tick();
        bus.ack_rdy = 1'b0;
        check("bp_idle_rdy", 64'(bus.req_rdy), 64'h1);
        tick();
        bus.req_vld = 1'b0;
        check("bp_next_sw_rd", 64'(sw_rd), 64'h1);
        tick();
        check("bp_next_rdata", 64'(bus.ack_rdata), 64'h1111_0000);
        complete("bp_next");

        // read-clear field returns the pre-clear value, then zero
        send(1'b0, 8'h08, '0);
        check("rc_sw_rd", 64'(sw_rd), 64'h4);
        tick();
        check("rc_rdata_old", 64'(bus.ack_rdata), 64'h3);
        complete("rc1");
        send(1'b0, 8'h08, '0);
        tick();
        check("rc_rdata_new", 64'(bus.ack_rdata), 64'h0);
        complete("rc2");

        // reset during ACCESS
        send(1'b1, 8'h00, 32'hCAFE_0000);
        check("rsta_sw_wr", 64'(sw_wr), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rsta_ack_vld", 64'(bus.ack_vld), 64'h0);
        check("rsta_strobes", 64'({sw_wr, sw_rd}), 64'h0);
        check("rsta_req_rdy", 64'(bus.req_rdy), 64'h1);
        tick();
        check("rsta_stay_idle", 64'(bus.ack_vld), 64'h0);

        // reset during RESP drops the pending ack
        send(1'b0, 8'h0C, '0);
        tick();
        check("rstr_ack_vld_pre", 64'(bus.ack_vld), 64'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstr_ack_vld", 64'(bus.ack_vld), 64'h0);
        check("rstr_ack_rdata", 64'(bus.ack_rdata), 64'h0);
        check("rstr_req_rdy", 64'(bus.req_rdy), 64'h1);

        // fresh read after reset
        reg1 = 32'h0BAD_F00D;
        send(1'b0, 8'h04, '0);
        check("fresh_sw_rd", 64'(sw_rd), 64'h2);
        tick();
        held = bus.ack_rdata;
        check("fresh_rdata", 64'(held), 64'h0BAD_F00D);
        check("fresh_err", 64'(bus.ack_err), 64'h0);
        complete("fresh");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog timeout");
    end

endmodule
